// File: rtl/simon_input_conditioner.sv
// Input conditioner for the Simon game core: synchronises the raw switches,
// debounces the push-button and emits one fixed-width pclk pulse per press.
module simon_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 4,
  parameter int CNT_W           = 20
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic [3:0] pattern_raw,
  input  logic       level_raw,
  output logic       pclk,
  output logic [3:0] pattern,
  output logic       level,
  output logic [7:0] press_count,
  output logic       busy
);

  // state   | meaning
  // IDLE    | button released and debounced; pattern tracks switches
  // ARM     | button seen high; counting consecutive high cycles
  // PULSE   | press accepted; pclk high, pattern frozen
  // HELD    | pulse finished; waiting for the button to drop
  // RELEASE | button seen low; counting consecutive low cycles

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_PULSE   = 3'd2,
    S_HELD    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PUL_TC = CNT_W'(PULSE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic       btn_meta, btn_s;
  logic [3:0] pat_meta, pat_s;
  logic       lvl_meta, lvl_s;

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      pat_meta <= 4'b0000;
      pat_s    <= 4'b0000;
      lvl_meta <= 1'b0;
      lvl_s    <= 1'b0;
    end else begin
      btn_meta <= btn_raw;
      btn_s    <= btn_meta;
      pat_meta <= pattern_raw;
      pat_s    <= pat_meta;
      lvl_meta <= level_raw;
      lvl_s    <= lvl_meta;
    end
  end

  // The core only samples level under its own reset, so no freezing here.
  assign level = lvl_s;

  // pclk and busy are set on the transition edge so they are clean flop outputs.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pclk        <= 1'b0;
      pattern     <= 4'b0000;
      press_count <= 8'd0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          pattern <= pat_s;
          if (btn_s) begin
            state <= S_ARM;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        S_ARM: begin
          if (!btn_s) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == DEB_TC) begin
            state       <= S_PULSE;
            cnt         <= '0;
            pattern     <= pat_s;
            press_count <= press_count + 8'd1;
            pclk        <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_PULSE: begin
          if (cnt == PUL_TC) begin
            state <= S_HELD;
            cnt   <= '0;
            pclk  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_HELD: begin
          pattern <= pat_s;
          if (!btn_s) begin
            state <= S_RELEASE;
            cnt   <= '0;
          end
        end

        S_RELEASE: begin
          pattern <= pat_s;
          if (btn_s) begin
            state <= S_HELD;
            cnt   <= '0;
          end else if (cnt == DEB_TC) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          pclk  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_input_conditioner.sv
// Self-checking bench for simon_input_conditioner: directed table, timing
// sequences and a randomized run against a run-length reference model.
module tb_simon_input_conditioner;

  localparam int D = 16;
  localparam int P = 4;

  logic       sysclk;
  logic       rst;
  logic       btn_raw;
  logic [3:0] pattern_raw;
  logic       level_raw;
  logic       pclk;
  logic [3:0] pattern;
  logic       level;
  logic [7:0] press_count;
  logic       busy;

  simon_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES(P),
    .CNT_W(20)
  ) dut (
    .sysclk(sysclk),
    .rst(rst),
    .btn_raw(btn_raw),
    .pattern_raw(pattern_raw),
    .level_raw(level_raw),
    .pclk(pclk),
    .pattern(pattern),
    .level(level),
    .press_count(press_count),
    .busy(busy)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference model: a press is accepted after D+1 consecutive high samples
  // of the synchronised button while ready; pclk then stays high for P
  // cycles; readiness returns after D+1 consecutive low samples.
  bit         m_ready;
  int         m_ones, m_zeros, m_pulse_left;
  logic [7:0] m_count;
  logic [3:0] m_pat;
  logic       m_pclk, m_busy;
  logic [1:0] m_bsh;
  logic [3:0] m_psh [2];
  logic [1:0] m_lsh;

  task automatic model_reset();
    m_ready = 1; m_ones = 0; m_zeros = 0; m_pulse_left = 0;
    m_count = 0; m_pat = 0; m_pclk = 0; m_busy = 0;
    m_bsh = 0; m_psh[0] = 0; m_psh[1] = 0; m_lsh = 0;
  endtask

  task automatic model_edge(input logic b, input logic [3:0] p, input logic l);
    logic       bs;
    logic [3:0] ps;
    bs = m_bsh[1];
    ps = m_psh[1];
    if (m_ready) begin
      if (m_ones == 0) m_pat = ps;
      if (bs) begin
        m_ones++;
        if (m_ones == D + 1) begin
          m_ready = 0; m_pulse_left = P; m_zeros = 0;
          m_count = m_count + 8'd1; m_pat = ps;
        end
      end else m_ones = 0;
    end else if (m_pulse_left > 0) begin
      m_pulse_left--;
    end else begin
      m_pat = ps;
      if (!bs) begin
        m_zeros++;
        if (m_zeros == D + 1) begin m_ready = 1; m_ones = 0; end
      end else m_zeros = 0;
    end
    m_pclk = !m_ready && (m_pulse_left > 0);
    m_busy = !(m_ready && m_ones == 0);
    m_bsh  = {m_bsh[0], b};
    m_psh[1] = m_psh[0]; m_psh[0] = p;
    m_lsh  = {m_lsh[0], l};
  endtask

  int         mon_rises, mon_high;
  logic [3:0] mon_pat;
  logic       mon_prev;

  task automatic reset_mon();
    mon_rises = 0; mon_high = 0; mon_pat = 0; mon_prev = pclk;
  endtask

  task automatic tick();
    logic       b, l;
    logic [3:0] p;
    b = btn_raw; p = pattern_raw; l = level_raw;
    @(posedge sysclk);
    #1;
    model_edge(b, p, l);
    if (pclk && !mon_prev) begin
      mon_rises++;
      if (mon_rises == 1) mon_pat = pattern;
    end
    if (pclk) mon_high++;
    mon_prev = pclk;
  endtask

  task automatic do_reset();
    rst = 1'b0; btn_raw = 1'b0; pattern_raw = 4'h0; level_raw = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    model_reset();
    reset_mon();
    rst = 1'b1;
  endtask

  task automatic wait_pclk(input int limit, output int edges, output bit found);
    found = 0; edges = 0;
    while (!found && edges < limit) begin
      tick();
      edges++;
      if (pclk) found = 1;
    end
  endtask

  typedef struct {
    int         press_len;
    logic [3:0] pat_idle;
    logic [3:0] pat_press;
    int         exp_pulses;
    int         exp_high;
    logic [3:0] exp_pat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int         e, w;
    bit         f;
    logic [7:0] cnt0;

    vecs[0] = '{16,  4'h3, 4'h5, 0, 0, 4'h0};
    vecs[1] = '{17,  4'h3, 4'h9, 1, 4, 4'h9};
    vecs[2] = '{40,  4'hA, 4'hC, 1, 4, 4'hC};
    vecs[3] = '{200, 4'hF, 4'h1, 1, 4, 4'h1};
    vecs[4] = '{2,   4'h6, 4'h6, 0, 0, 4'h0};
    vecs[5] = '{1,   4'h0, 4'h7, 0, 0, 4'h0};

    rst = 1'b0; btn_raw = 1'b0; pattern_raw = 4'h0; level_raw = 1'b0;
    mon_prev = 1'b0;
    #3;
    check("rst_pclk", pclk, 0);
    check("rst_pattern", pattern, 0);
    check("rst_level", level, 0);
    check("rst_count", press_count, 0);
    check("rst_busy", busy, 0);

    // Clean press latency: pclk high on edges D+3 .. D+3+P-1.
    do_reset();
    btn_raw = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      check($sformatf("lat_pclk_e%0d", k), pclk, (k >= 19 && k <= 22) ? 1 : 0);
      check($sformatf("lat_busy_e%0d", k), busy, (k >= 3) ? 1 : 0);
    end
    btn_raw = 1'b0;
    repeat (30) tick();
    check("lat_count", press_count, 1);
    check("lat_busy_end", busy, 0);

    // Table of press lengths with a pattern change at press start.
    do_reset();
    for (int v = 0; v < 6; v++) begin
      pattern_raw = vecs[v].pat_idle;
      repeat (5) tick();
      reset_mon();
      cnt0 = press_count;
      btn_raw = 1'b1;
      pattern_raw = vecs[v].pat_press;
      repeat (vecs[v].press_len) tick();
      btn_raw = 1'b0;
      repeat (50) tick();
      check($sformatf("vec%0d_pulses", v), mon_rises, vecs[v].exp_pulses);
      check($sformatf("vec%0d_width", v), mon_high, vecs[v].exp_high);
      check($sformatf("vec%0d_pat", v), mon_pat, vecs[v].exp_pat);
      check($sformatf("vec%0d_count", v), 8'(press_count - cnt0), vecs[v].exp_pulses);
      check($sformatf("vec%0d_busy", v), busy, 0);
    end

    // Bounce shorter than the debounce window never produces a pulse.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      btn_raw = ((i / 5) % 2 == 0);
      tick();
    end
    btn_raw = 1'b0;
    repeat (30) tick();
    check("bounce_pulses", mon_rises, 0);
    check("bounce_count", press_count, 0);
    check("bounce_busy", busy, 0);

    // Pattern frozen for the whole pulse, updated right after.
    do_reset();
    pattern_raw = 4'b1010;
    repeat (5) tick();
    btn_raw = 1'b1;
    wait_pclk(40, e, f);
    check("frz_pulse_seen", f, 1);
    pattern_raw = 4'b0110;
    check("frz_pat_rise", pattern, 4'b1010);
    w = 1;
    f = 0;
    while (!f && w < 10) begin
      tick();
      if (!pclk) f = 1;
      else begin
        check("frz_pat_hold", pattern, 4'b1010);
        w++;
      end
    end
    check("frz_width", w, P);
    tick();
    check("frz_pat_after", pattern, 4'b0110);
    btn_raw = 1'b0;
    repeat (40) tick();

    // Long hold, bouncy release, second press.
    do_reset();
    btn_raw = 1'b1;
    repeat (200) tick();
    for (int i = 0; i < 3; i++) begin
      btn_raw = 1'b0; repeat (3) tick();
      btn_raw = 1'b1; repeat (2) tick();
    end
    btn_raw = 1'b0; repeat (40) tick();
    btn_raw = 1'b1; repeat (30) tick();
    btn_raw = 1'b0; repeat (40) tick();
    check("hold_pulses", mon_rises, 2);
    check("hold_count", press_count, 2);

    // 256 clean presses wrap the counter.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      btn_raw = 1'b1; repeat (20) tick();
      btn_raw = 1'b0; repeat (25) tick();
      if (i == 254) check("wrap_count_255", press_count, 255);
    end
    check("wrap_pulses", mon_rises, 256);
    check("wrap_count", press_count, 0);

    // Asynchronous reset in the second pulse cycle, button still held.
    do_reset();
    pattern_raw = 4'hF;
    btn_raw = 1'b1;
    wait_pclk(40, e, f);
    check("arst_pulse_seen", f, 1);
    tick();
    check("arst_pre_pclk", pclk, 1);
    check("arst_pre_pat", pattern, 4'hF);
    check("arst_pre_count", press_count, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_pclk", pclk, 0);
    check("arst_pat", pattern, 0);
    check("arst_count", press_count, 0);
    check("arst_busy", busy, 0);
    model_reset();
    #1 rst = 1'b1;
    reset_mon();
    wait_pclk(40, e, f);
    check("arst_repulse_edge", e, 19);
    btn_raw = 1'b0;
    repeat (40) tick();

    // Level follows after the two-flop synchroniser.
    do_reset();
    level_raw = 1'b1;
    tick();
    check("lvl_e1", level, 0);
    tick();
    check("lvl_e2", level, 1);
    check("lvl_pclk", pclk, 0);
    repeat (3) tick();
    check("lvl_busy", busy, 0);

    // Randomized run against the reference model.
    do_reset();
    for (int seg = 0; seg < 120; seg++) begin
      int len;
      btn_raw = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 7) == 0) pattern_raw = 4'($urandom);
        if ($urandom_range(0, 15) == 0) level_raw = ~level_raw;
        tick();
        check("rand_pclk", pclk, m_pclk);
        check("rand_busy", busy, m_busy);
        check("rand_pattern", pattern, m_pat);
        check("rand_level", level, m_lsh[1]);
        check("rand_count", press_count, m_count);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
